// File: rtl/eth_rx_parser.sv
// eth_rx_parser: receive side of the Galapagos Ethernet link.
// Parses the 16-byte header carried in the first two 64-bit beats of each
// frame, filters on destination MAC and ethertype, and forwards the payload
// beats through a single output register. The kernel dest ID and source MAC
// are forwarded as sideband meta. Rejected frames are drained.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   stream_in_*              raw frame AXI-stream (DATA/KEEP/LAST/VALID/READY)
//   stream_out_*             payload AXI-stream (DATA/KEEP/LAST/VALID/READY)
//   out_dest, out_src_mac    meta for the frame currently on stream_out
//   frames_ok/frames_dropped frame statistics, wrapping counters
//   dbg_state_o              current parser state (HDR0=0 HDR1=1 PAYLOAD=2 DROP=3)
//
// Handshake: a beat transfers on a rising edge where VALID and READY are both
// high. A source holds DATA/KEEP/LAST stable while VALID is high and READY is
// low, and it does not drop VALID before the transfer.
module eth_rx_parser #(
  parameter logic [47:0] MAC_ADDR     = 48'hfa163e55ca02,
  parameter logic [15:0] ETHERTYPE    = 16'h7400,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int          CNT_W        = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [63:0]      stream_in_DATA,
  input  logic [7:0]       stream_in_KEEP,
  input  logic             stream_in_LAST,
  input  logic             stream_in_VALID,
  output logic             stream_in_READY,
  output logic [63:0]      stream_out_DATA,
  output logic [7:0]       stream_out_KEEP,
  output logic             stream_out_LAST,
  output logic             stream_out_VALID,
  input  logic             stream_out_READY,
  output logic [7:0]       out_dest,
  output logic [47:0]      out_src_mac,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_dropped,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {S_HDR0 = 2'd0, S_HDR1 = 2'd1, S_PAYLOAD = 2'd2, S_DROP = 2'd3} state_e;

  state_e state_q, state_d;
  logic   in_ready;
  logic   in_fire, push, pop;

  logic             match_q, match_d;
  logic [15:0]      src_hi_q, src_hi_d;
  logic [7:0]       dest_q, dest_d;
  logic [47:0]      src_q, src_d;
  logic [63:0]      data_q, data_d;
  logic [7:0]       keep_q, keep_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] ok_q, ok_d, drop_q, drop_d;

  // Header fields; wire byte 0 sits in lane 0 and is the MSB of a MAC.
  logic [47:0] b0_dst;
  logic [15:0] b0_src_hi;
  logic [31:0] b1_src_lo;
  logic [15:0] b1_type;
  logic [7:0]  b1_dest;
  logic        dst_hit;

  assign b0_dst    = {stream_in_DATA[7:0], stream_in_DATA[15:8], stream_in_DATA[23:16],
                      stream_in_DATA[31:24], stream_in_DATA[39:32], stream_in_DATA[47:40]};
  assign b0_src_hi = {stream_in_DATA[55:48], stream_in_DATA[63:56]};
  assign b1_src_lo = {stream_in_DATA[7:0], stream_in_DATA[15:8], stream_in_DATA[23:16],
                      stream_in_DATA[31:24]};
  assign b1_type   = {stream_in_DATA[39:32], stream_in_DATA[47:40]};
  assign b1_dest   = stream_in_DATA[55:48];
  assign dst_hit   = (b0_dst == MAC_ADDR) || (ACCEPT_BCAST && (b0_dst == 48'hffffffffffff));

  assign in_fire = stream_in_VALID & in_ready;
  assign push    = in_fire & (state_q == S_PAYLOAD);
  assign pop     = valid_q & stream_out_READY;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= S_HDR0;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (in_fire) begin
      case (state_q)
        S_HDR0:    if (!stream_in_LAST) state_d = S_HDR1;
        S_HDR1: begin
          if (stream_in_LAST)                          state_d = S_HDR0;
          else if (match_q && (b1_type == ETHERTYPE)) state_d = S_PAYLOAD;
          else                                         state_d = S_DROP;
        end
        S_PAYLOAD: if (stream_in_LAST) state_d = S_HDR0;
        S_DROP:    if (stream_in_LAST) state_d = S_HDR0;
        default:   state_d = S_HDR0;
      endcase
    end
  end

  // Output logic. HDR1 waits for an empty output register so the meta of the
  // previous frame stays put until its last beat has left.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_HDR0:    in_ready = 1'b1;
      S_HDR1:    in_ready = ~valid_q;
      S_PAYLOAD: in_ready = ~valid_q | stream_out_READY;
      S_DROP:    in_ready = 1'b1;
      default:   in_ready = 1'b0;
    endcase
    // Held low for the whole time reset is asserted, not just until the edge.
    in_ready = in_ready & aresetn;
  end

  // Datapath next-state
  always_comb begin
    match_d  = match_q;
    src_hi_d = src_hi_q;
    dest_d   = dest_q;
    src_d    = src_q;
    data_d   = data_q;
    keep_d   = keep_q;
    last_d   = last_q;
    valid_d  = valid_q;
    ok_d     = ok_q;
    drop_d   = drop_q;

    if (in_fire && state_q == S_HDR0) begin
      match_d  = dst_hit;
      src_hi_d = b0_src_hi;
    end
    if (in_fire && state_q == S_HDR1 && !stream_in_LAST &&
        match_q && (b1_type == ETHERTYPE)) begin
      dest_d = b1_dest;
      src_d  = {src_hi_q, b1_src_lo};
    end

    if (push) begin
      data_d  = stream_in_DATA;
      keep_d  = stream_in_KEEP;
      last_d  = stream_in_LAST;
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end

    if (in_fire && stream_in_LAST) begin
      if (state_q == S_PAYLOAD) ok_d   = ok_q + CNT_W'(1);
      else                      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      match_q  <= 1'b0;
      src_hi_q <= '0;
      dest_q   <= '0;
      src_q    <= '0;
      data_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      ok_q     <= '0;
      drop_q   <= '0;
    end else begin
      match_q  <= match_d;
      src_hi_q <= src_hi_d;
      dest_q   <= dest_d;
      src_q    <= src_d;
      data_q   <= data_d;
      keep_q   <= keep_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      ok_q     <= ok_d;
      drop_q   <= drop_d;
    end
  end

  assign stream_in_READY  = in_ready;
  assign stream_out_DATA  = data_q;
  assign stream_out_KEEP  = keep_q;
  assign stream_out_LAST  = last_q;
  assign stream_out_VALID = valid_q;
  assign out_dest         = dest_q;
  assign out_src_mac      = src_q;
  assign frames_ok        = ok_q;
  assign frames_dropped   = drop_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_eth_rx_parser.sv
// Testbench for eth_rx_parser. u_dut uses default parameters; u_nobc has
// broadcast acceptance disabled and only sees traffic while sel_b is high.
module tb_eth_rx_parser;

  localparam logic [47:0] MY_MAC = 48'hfa163e55ca02;
  localparam logic [47:0] SRC    = 48'h0cc47a88c047;
  localparam logic [47:0] BCAST  = 48'hffffffffffff;

  // ---------------- clock / reset ----------------
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- DUT signals ----------------
  logic [63:0] in_data  = '0;
  logic [7:0]  in_keep  = '0;
  logic        in_last  = 1'b0;
  logic        in_valid = 1'b0;
  logic        sel_b    = 1'b0;
  logic        in_valid_a, in_valid_b;
  assign in_valid_a = in_valid & ~sel_b;
  assign in_valid_b = in_valid & sel_b;

  logic        rdy_a, out_last, out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [7:0]  out_keep, out_dest;
  logic [47:0] out_src;
  logic [31:0] ok_a, drop_a;
  logic [1:0]  dbg_a;

  logic        rdy_b, b_last, b_valid;
  logic        b_ready = 1'b1;
  logic [63:0] b_data;
  logic [7:0]  b_keep, b_dest;
  logic [47:0] b_src;
  logic [31:0] ok_b, drop_b;
  logic [1:0]  dbg_b;

  eth_rx_parser u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .stream_in_DATA(in_data), .stream_in_KEEP(in_keep), .stream_in_LAST(in_last),
    .stream_in_VALID(in_valid_a), .stream_in_READY(rdy_a),
    .stream_out_DATA(out_data), .stream_out_KEEP(out_keep), .stream_out_LAST(out_last),
    .stream_out_VALID(out_valid), .stream_out_READY(out_ready),
    .out_dest(out_dest), .out_src_mac(out_src),
    .frames_ok(ok_a), .frames_dropped(drop_a), .dbg_state_o(dbg_a)
  );

  eth_rx_parser #(.ACCEPT_BCAST(1'b0)) u_nobc (
    .aclk(aclk), .aresetn(aresetn),
    .stream_in_DATA(in_data), .stream_in_KEEP(in_keep), .stream_in_LAST(in_last),
    .stream_in_VALID(in_valid_b), .stream_in_READY(rdy_b),
    .stream_out_DATA(b_data), .stream_out_KEEP(b_keep), .stream_out_LAST(b_last),
    .stream_out_VALID(b_valid), .stream_out_READY(b_ready),
    .out_dest(b_dest), .out_src_mac(b_src),
    .frames_ok(ok_b), .frames_dropped(drop_b), .dbg_state_o(dbg_b)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected beat: {src_mac[47:0], dest[7:0], last, keep[7:0], data[63:0]}
  logic [128:0] exp_q[$];
  int pop_cnt    = 0;
  int stall_seen = 0;
  int hdr1_waits = 0;
  int rdy_mode   = 0;  // 0: always ready, 1: toggle, 2: never ready

  // Downstream ready driver, changes only on the falling edge.
  initial forever begin
    @(negedge aclk);
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  end

  // Output monitor: values sampled here are what the next rising edge sees.
  initial begin
    logic         held_v;
    logic [72:0]  held;
    logic [128:0] e;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge aclk);
      #2;
      if (!aresetn) begin
        held_v = 1'b0;
      end else begin
        if (b_valid) chk("nobc_no_output", b_valid, 1'b0);
        if (out_valid) begin
          if (held_v) chk("hold_stable", {out_last, out_keep, out_data}, held);
          if (out_ready) begin
            held_v = 1'b0;
            pop_cnt++;
            if (exp_q.size() == 0) begin
              chk("unexpected_beat", {out_last, out_keep, out_data}, '1);
            end else begin
              e = exp_q.pop_front();
              chk("beat", {out_last, out_keep, out_data}, e[72:0]);
              chk("meta", {out_src, out_dest}, e[128:73]);
            end
          end else begin
            held_v = 1'b1;
            held   = {out_last, out_keep, out_data};
          end
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  function automatic logic [63:0] hdr0(input logic [47:0] dst, input logic [47:0] src);
    return {src[39:32], src[47:40], dst[7:0], dst[15:8], dst[23:16], dst[31:24],
            dst[39:32], dst[47:40]};
  endfunction

  function automatic logic [63:0] hdr1(input logic [47:0] src, input logic [15:0] et,
                                       input logic [7:0] dest);
    return {8'h00, dest, et[7:0], et[15:8], src[7:0], src[15:8], src[23:16], src[31:24]};
  endfunction

  // Entered and left on a falling edge; one beat per call.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           output int waits);
    bit done;
    int n;
    done     = 1'b0;
    n        = 0;
    waits    = 0;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_valid = 1'b1;
    while (!done && n < 500) begin
      #1;
      done = sel_b ? rdy_b : rdy_a;
      if (!done) waits++;
      @(negedge aclk);
      n++;
    end
    in_valid = 1'b0;
    if (waits > 0) stall_seen = 1;
    if (!done) chk("in_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] dest,
                            input int npay, input logic [7:0] lastkeep, input bit good,
                            input logic [31:0] seed);
    int w;
    logic [63:0] d;
    logic [7:0]  k;
    send_beat(hdr0(dst, SRC), 8'hff, 1'b0, w);
    send_beat(hdr1(SRC, et, dest), 8'hff, npay == 0, w);
    hdr1_waits = w;
    for (int i = 0; i < npay; i++) begin
      d = {seed, 32'(i)};
      k = (i == npay - 1) ? lastkeep : 8'hff;
      if (good) exp_q.push_back({SRC, dest, (i == npay - 1), k, d});
      send_beat(d, k, i == npay - 1, w);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge aclk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int pc0;
    @(negedge aclk);
    #1;
    chk("rst_in_ready", rdy_a, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_counters", {ok_a, drop_a}, 64'h0);
    chk("rst_meta", {out_src, out_dest}, 56'h0);
    chk("rst_state", dbg_a, 2'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // 1: good frame, 3 payload beats
    send_frame(MY_MAC, 16'h7400, 8'h05, 3, 8'h0f, 1'b1, 32'ha1a1a1a1);
    wait_drain();
    chk("t1_pop_cnt", pop_cnt, 3);
    chk("t1_dest", out_dest, 8'h05);
    chk("t1_src", out_src, 48'h0cc47a88c047);
    chk("t1_ok", ok_a, 1);
    chk("t1_drop", drop_a, 0);

    // 2: wrong dst MAC, drained with READY high throughout
    stall_seen = 0;
    pc0 = pop_cnt;
    send_frame(48'h0cc47a88c048, 16'h7400, 8'h05, 3, 8'h0f, 1'b0, 32'hb2b2b2b2);
    wait_drain();
    chk("t2_no_stall", stall_seen, 0);
    chk("t2_no_output", pop_cnt, pc0);
    chk("t2_drop", drop_a, 1);
    chk("t2_ok", ok_a, 1);

    // 3: wrong ethertype, then broadcast on both instances
    send_frame(MY_MAC, 16'h0800, 8'h05, 2, 8'hff, 1'b0, 32'hc3c3c3c3);
    wait_drain();
    chk("t3_etype_drop", drop_a, 2);
    send_frame(BCAST, 16'h7400, 8'h09, 2, 8'h03, 1'b1, 32'hc4c4c4c4);
    wait_drain();
    chk("t3_bcast_ok", ok_a, 2);
    chk("t3_bcast_dest", out_dest, 8'h09);
    sel_b = 1'b1;
    send_frame(BCAST, 16'h7400, 8'h09, 2, 8'h03, 1'b0, 32'hc5c5c5c5);
    sel_b = 1'b0;
    repeat (3) @(negedge aclk);
    chk("t3_nobc_drop", drop_b, 1);
    chk("t3_nobc_ok", ok_b, 0);

    // 4: toggled downstream ready over 8 beats, then back-to-back frames
    pc0 = pop_cnt;
    rdy_mode = 1;
    send_frame(MY_MAC, 16'h7400, 8'h11, 8, 8'h7f, 1'b1, 32'hd4d4d4d4);
    wait_drain();
    chk("t4_pop_cnt", pop_cnt - pc0, 8);
    chk("t4_ok", ok_a, 3);
    send_frame(MY_MAC, 16'h7400, 8'h12, 4, 8'hff, 1'b1, 32'hd5d5d5d5);
    rdy_mode = 2;
    fork
      send_frame(MY_MAC, 16'h7400, 8'h06, 2, 8'h01, 1'b1, 32'hd6d6d6d6);
      begin
        repeat (4) @(negedge aclk);
        rdy_mode = 0;
      end
    join
    wait_drain();
    chk("t4_hdr1_held", hdr1_waits >= 2, 1'b1);
    chk("t4_ok2", ok_a, 5);
    chk("t4_dest2", out_dest, 8'h06);

    // 5: runt on beat0, runt on beat1, then a good frame
    pc0 = pop_cnt;
    send_beat(hdr0(MY_MAC, SRC), 8'hff, 1'b1, w);
    send_frame(MY_MAC, 16'h7400, 8'h07, 0, 8'hff, 1'b0, 32'he7e7e7e7);
    repeat (3) @(negedge aclk);
    chk("t5_runt_drop", drop_a, 4);
    chk("t5_runt_no_output", pop_cnt, pc0);
    send_frame(MY_MAC, 16'h7400, 8'h08, 1, 8'h3f, 1'b1, 32'he8e8e8e8);
    wait_drain();
    chk("t5_ok", ok_a, 6);
    chk("t5_dest", out_dest, 8'h08);

    // 6: reset pulsed mid-payload with a beat stuck in the output register
    rdy_mode = 2;
    send_beat(hdr0(MY_MAC, SRC), 8'hff, 1'b0, w);
    send_beat(hdr1(SRC, 16'h7400, 8'h0a), 8'hff, 1'b0, w);
    send_beat(64'h1234567890abcdef, 8'hff, 1'b0, w);
    repeat (2) @(negedge aclk);
    chk("t6_stuck_valid", out_valid, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("t6_in_ready", rdy_a, 1'b0);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_counters", {ok_a, drop_a}, 64'h0);
    chk("t6_meta", {out_src, out_dest}, 56'h0);
    chk("t6_state", dbg_a, 2'd0);
    exp_q.delete();
    rdy_mode = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    send_frame(MY_MAC, 16'h7400, 8'h0b, 2, 8'h0f, 1'b1, 32'hf9f9f9f9);
    wait_drain();
    chk("t6_ok", ok_a, 1);
    chk("t6_drop", drop_a, 0);
    chk("t6_dest", out_dest, 8'h0b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
